// File: rtl/pim_dma_pkg.sv
// Shared types and constants for the PIM DMA engine: FSM states, opcodes,
// and the byte-count to word-count conversion.
package pim_dma_pkg;

    localparam int SIZE_W = 13;
    localparam int WCNT_W = 12;

    localparam logic [2:0] DMA_F3_MEM2PIM = 3'b000;
    localparam logic [2:0] DMA_F3_PIM2MEM = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MRD_REQ,
        S_MRD_DATA,
        S_PRD,
        S_MWR_REQ,
        S_DONE
    } dma_state_e;

    typedef logic [WCNT_W-1:0] wcnt_t;

    // A partial trailing word still needs a full-word transfer, so round up.
    function automatic wcnt_t bytes_to_words(input logic [SIZE_W-1:0] size);
        logic [SIZE_W:0] sum;
        sum = {1'b0, size} + (SIZE_W + 1)'(3);
        return sum[SIZE_W:2];
    endfunction

endpackage

// File: rtl/pim_dma_agen.sv
// Address generator: holds the word-aligned base, the word index and the word
// count, and derives memory/PIM addresses plus the last-word flag.
module pim_dma_agen
    import pim_dma_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PIM_AW = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [XLEN-1:0]   base_i,
    input  wcnt_t             words_i,
    input  logic              inc_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [PIM_AW-1:0] pim_addr_o,
    output logic              last_o
);

    logic [XLEN-1:0] base_q;
    wcnt_t           idx_q;
    wcnt_t           words_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q  <= '0;
            idx_q   <= '0;
            words_q <= '0;
        end else if (load_i) begin
            base_q  <= base_i & ~XLEN'(3);
            idx_q   <= '0;
            words_q <= words_i;
        end else if (inc_i) begin
            idx_q   <= idx_q + WCNT_W'(1);
        end
    end

    // Wrapping past the top of the address space is intentional and silent.
    assign mem_addr_o = base_q + XLEN'({idx_q, 2'b00});
    assign pim_addr_o = idx_q[PIM_AW-1:0];
    assign last_o     = (idx_q == words_q - WCNT_W'(1));

endmodule

// File: rtl/pim_dma_ctrl.sv
// DMA engine moving 32-bit words between data memory and one PIM macro,
// stalling the core through dma_busy_o until the transfer completes.
module pim_dma_ctrl
    import pim_dma_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PIM_AW = 11,
    parameter int N_PIM  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dma_en_i,
    input  logic [2:0]        dma_funct3_i,
    input  logic [N_PIM-1:0]  dma_sel_pim_i,
    input  logic [12:0]       dma_size_i,
    input  logic [XLEN-1:0]   dma_mem_addr_i,
    output logic              dma_busy_o,
    output logic              dma_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wr_data_o,
    input  logic [XLEN-1:0]   mem_rd_data_i,
    output logic [3:0]        mem_size_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [N_PIM-1:0]  pim_sel_o,
    output logic [PIM_AW-1:0] pim_addr_o,
    output logic [XLEN-1:0]   pim_wdata_o,
    output logic              pim_we_o,
    output logic              pim_re_o,
    input  logic [XLEN-1:0]   pim_rdata_i
);

    function automatic logic is_onehot(input logic [N_PIM-1:0] v);
        return (v != '0) && ((v & (v - N_PIM'(1))) == '0);
    endfunction

    dma_state_e       state_q;
    logic [N_PIM-1:0] sel_q;
    logic [XLEN-1:0]  data_q;
    logic             busy_q;
    logic             err_q;
    logic [3:0]       size_q;

    logic              accept;
    logic              legal;
    wcnt_t             words_in;
    logic              agen_inc;
    logic              agen_last;
    logic [XLEN-1:0]   agen_mem_addr;
    logic [PIM_AW-1:0] agen_pim_addr;

    assign accept   = (state_q == S_IDLE) && dma_en_i;
    assign words_in = bytes_to_words(dma_size_i);
    assign legal    = ((dma_funct3_i == DMA_F3_MEM2PIM) || (dma_funct3_i == DMA_F3_PIM2MEM))
                      && is_onehot(dma_sel_pim_i);
    assign agen_inc = (state_q == S_MRD_DATA) || ((state_q == S_MWR_REQ) && mem_gnt_i);

    pim_dma_agen #(
        .XLEN   (XLEN),
        .PIM_AW (PIM_AW)
    ) u_agen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (accept),
        .base_i     (dma_mem_addr_i),
        .words_i    (words_in),
        .inc_i      (agen_inc),
        .mem_addr_o (agen_mem_addr),
        .pim_addr_o (agen_pim_addr),
        .last_o     (agen_last)
    );

    // Illegal commands still pass through DONE so the core sees one busy cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
        end else begin
            err_q  <= 1'b0;
            size_q <= 4'b1111;
            unique case (state_q)
                S_IDLE: begin
                    if (dma_en_i) begin
                        sel_q  <= dma_sel_pim_i;
                        busy_q <= 1'b1;
                        if (!legal) begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                        end else if (words_in == '0) begin
                            state_q <= S_DONE;
                        end else if (dma_funct3_i == DMA_F3_MEM2PIM) begin
                            state_q <= S_MRD_REQ;
                        end else begin
                            state_q <= S_PRD;
                        end
                    end
                end
                S_MRD_REQ: begin
                    if (mem_gnt_i) state_q <= S_MRD_DATA;
                end
                S_MRD_DATA: begin
                    state_q <= agen_last ? S_DONE : S_MRD_REQ;
                end
                S_PRD: begin
                    data_q  <= pim_rdata_i;
                    state_q <= S_MWR_REQ;
                end
                S_MWR_REQ: begin
                    if (mem_gnt_i) state_q <= agen_last ? S_DONE : S_PRD;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dma_busy_o    = busy_q;
    assign dma_err_o     = err_q;
    assign mem_size_o    = size_q;
    assign mem_read_o    = (state_q == S_MRD_REQ);
    assign mem_write_o   = (state_q == S_MWR_REQ);
    assign mem_req_o     = mem_read_o || mem_write_o;
    assign mem_addr_o    = mem_req_o ? agen_mem_addr : '0;
    assign mem_wr_data_o = mem_write_o ? data_q : '0;
    assign pim_we_o      = (state_q == S_MRD_DATA);
    assign pim_re_o      = (state_q == S_PRD);
    assign pim_addr_o    = (pim_we_o || pim_re_o) ? agen_pim_addr : '0;
    assign pim_wdata_o   = pim_we_o ? mem_rd_data_i : '0;
    assign pim_sel_o     = (state_q != S_IDLE) ? sel_q : '0;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Directed bench for pim_dma_ctrl with behavioural memory and PIM models.
module tb_pim_dma_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dmaEn = 1'b0;
    logic [2:0]  dmaFunct3 = '0;
    logic [3:0]  dmaSel = '0;
    logic [12:0] dmaSize = '0;
    logic [31:0] dmaAddr = '0;
    logic        dmaBusy, dmaErr, memReq, memGnt, memRead, memWrite, pimWe, pimRe;
    logic [31:0] memAddr, memWrData, pimWdata, pimRdata;
    logic [31:0] memRdData = '0;
    logic [3:0]  memSize, pimSel;
    logic [10:0] pimAddr;

    int testsRun = 0;
    int testsFailed = 0;
    int gntDelay = 0;
    int waitCnt = 0;

    int busyCycles, errPulses, strobes, unstable;
    logic prevValid;
    logic [31:0] prevAddr, prevWd;
    logic [3:0] selSeen, sizeSeen;
    logic [31:0] rdAddr[$], wrAddr[$], wrData[$], pimWAddr[$], pimWData[$];

    pim_dma_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .dma_en_i       (dmaEn),
        .dma_funct3_i   (dmaFunct3),
        .dma_sel_pim_i  (dmaSel),
        .dma_size_i     (dmaSize),
        .dma_mem_addr_i (dmaAddr),
        .dma_busy_o     (dmaBusy),
        .dma_err_o      (dmaErr),
        .mem_req_o      (memReq),
        .mem_gnt_i      (memGnt),
        .mem_addr_o     (memAddr),
        .mem_wr_data_o  (memWrData),
        .mem_rd_data_i  (memRdData),
        .mem_size_o     (memSize),
        .mem_read_o     (memRead),
        .mem_write_o    (memWrite),
        .pim_sel_o      (pimSel),
        .pim_addr_o     (pimAddr),
        .pim_wdata_o    (pimWdata),
        .pim_we_o       (pimWe),
        .pim_re_o       (pimRe),
        .pim_rdata_i    (pimRdata)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Grant either tied high or withheld for gntDelay cycles of each request.
    assign memGnt   = (gntDelay == 0) ? 1'b1 : (memReq && (waitCnt >= gntDelay));
    assign pimRdata = 32'hC0DE_0000 | {21'd0, pimAddr};

    always @(posedge clk_i) begin
        waitCnt   <= (memReq && !memGnt) ? waitCnt + 1 : 0;
        memRdData <= (memReq && memRead && memGnt) ? memModel(memAddr) : 32'hDEAD_BEEF;
    end

    always @(negedge clk_i) begin
        if (dmaBusy) busyCycles++;
        if (dmaErr) errPulses++;
        if (memReq || pimWe || pimRe) strobes++;
        if (memRead && memGnt) rdAddr.push_back(memAddr);
        if (memWrite && memGnt) begin
            wrAddr.push_back(memAddr);
            wrData.push_back(memWrData);
        end
        if (pimWe) begin
            pimWAddr.push_back({21'd0, pimAddr});
            pimWData.push_back(pimWdata);
            selSeen = pimSel;
        end
        if (memReq) begin
            sizeSeen = memSize;
            if (prevValid && (memAddr != prevAddr || memWrData != prevWd)) unstable++;
            prevValid = !memGnt;
            prevAddr  = memAddr;
            prevWd    = memWrData;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearLogs();
        busyCycles = 0; errPulses = 0; strobes = 0; unstable = 0;
        prevValid = 1'b0; selSeen = '0; sizeSeen = '0;
        rdAddr.delete(); wrAddr.delete(); wrData.delete();
        pimWAddr.delete(); pimWData.delete();
    endtask

    task automatic issueCmd(input logic [2:0] f3, input logic [3:0] sel,
                            input logic [12:0] size, input logic [31:0] addr);
        @(negedge clk_i);
        clearLogs();
        dmaEn = 1'b1; dmaFunct3 = f3; dmaSel = sel; dmaSize = size; dmaAddr = addr;
        @(negedge clk_i);
        dmaEn = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [3:0] sel,
                                 input logic [12:0] size, input logic [31:0] addr);
        int n;
        issueCmd(f3, sel, size, addr);
        n = 0;
        while (dmaBusy && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        #1;
        checkOutput({tag, "_completes"}, 32'(n < 500), 32'd1);
    endtask

    initial begin
        int n;
        clearLogs();
        #12;
        checkOutput("rst_busy", 32'(dmaBusy), 32'd0);
        checkOutput("rst_err", 32'(dmaErr), 32'd0);
        checkOutput("rst_req", 32'(memReq), 32'd0);
        checkOutput("rst_size", 32'(memSize), 32'd0);
        checkOutput("rst_sel", 32'(pimSel), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // MEM->PIM, 4 words, grant tied high: 2 cycles/word + DONE.
        gntDelay = 0;
        applyStimulus("m2p", 3'b000, 4'b0010, 13'd16, 32'h2000_0000);
        checkOutput("m2p_busy", busyCycles, 9);
        checkOutput("m2p_err", errPulses, 0);
        checkOutput("m2p_nrd", rdAddr.size(), 4);
        checkOutput("m2p_nwr", pimWAddr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("m2p_rdaddr%0d", i), rdAddr[i], 32'h2000_0000 + 32'(4 * i));
            checkOutput($sformatf("m2p_pimaddr%0d", i), pimWAddr[i], 32'(i));
            checkOutput($sformatf("m2p_pimdata%0d", i), pimWData[i], memModel(32'h2000_0000 + 32'(4 * i)));
        end
        checkOutput("m2p_sel", 32'(selSeen), 32'h2);
        checkOutput("m2p_bytemask", 32'(sizeSeen), 32'hF);

        // PIM->MEM, 2 words, grant withheld 4 cycles per request: 1 + 2*(2+4) = 13.
        gntDelay = 4;
        applyStimulus("p2m", 3'b001, 4'b0100, 13'd8, 32'h2000_0100);
        checkOutput("p2m_busy", busyCycles, 13);
        checkOutput("p2m_nwr", wrAddr.size(), 2);
        checkOutput("p2m_addr0", wrAddr[0], 32'h2000_0100);
        checkOutput("p2m_addr1", wrAddr[1], 32'h2000_0104);
        checkOutput("p2m_data0", wrData[0], 32'hC0DE_0000);
        checkOutput("p2m_data1", wrData[1], 32'hC0DE_0001);
        checkOutput("p2m_stable", unstable, 0);
        checkOutput("p2m_err", errPulses, 0);

        // Unaligned base and partial trailing word.
        gntDelay = 0;
        applyStimulus("odd", 3'b000, 4'b0001, 13'd5, 32'h2000_0003);
        checkOutput("odd_nrd", rdAddr.size(), 2);
        checkOutput("odd_addr0", rdAddr[0], 32'h2000_0000);
        checkOutput("odd_addr1", rdAddr[1], 32'h2000_0004);

        // Address wrap past the top of memory.
        applyStimulus("wrap", 3'b000, 4'b1000, 13'd8, 32'hFFFF_FFFC);
        checkOutput("wrap_addr0", rdAddr[0], 32'hFFFF_FFFC);
        checkOutput("wrap_addr1", rdAddr[1], 32'h0000_0000);
        checkOutput("wrap_err", errPulses, 0);

        applyStimulus("zero", 3'b000, 4'b0010, 13'd0, 32'h2000_0000);
        checkOutput("zero_busy", busyCycles, 1);
        checkOutput("zero_strobes", strobes, 0);
        checkOutput("zero_err", errPulses, 0);

        applyStimulus("badf3", 3'b111, 4'b0010, 13'd16, 32'h2000_0000);
        checkOutput("badf3_err", errPulses, 1);
        checkOutput("badf3_busy", busyCycles, 1);
        checkOutput("badf3_strobes", strobes, 0);

        applyStimulus("badsel", 3'b000, 4'b0110, 13'd16, 32'h2000_0000);
        checkOutput("badsel_err", errPulses, 1);
        checkOutput("badsel_busy", busyCycles, 1);
        checkOutput("badsel_strobes", strobes, 0);

        // Abort with reset while word 2 of 4 waits for its write grant.
        gntDelay = 4;
        issueCmd(3'b001, 4'b0001, 13'd16, 32'h3000_0000);
        n = 0;
        while (!(wrAddr.size() == 1 && memWrite && !memGnt) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("abort_reached", 32'(n < 200), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(dmaBusy), 32'd0);
        checkOutput("abort_req", 32'(memReq), 32'd0);
        checkOutput("abort_write", 32'(memWrite), 32'd0);
        checkOutput("abort_addr", memAddr, 32'd0);
        checkOutput("abort_wdata", memWrData, 32'd0);
        checkOutput("abort_sel", 32'(pimSel), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        gntDelay = 0;
        applyStimulus("restart", 3'b000, 4'b0010, 13'd8, 32'h4000_0010);
        checkOutput("restart_busy", busyCycles, 5);
        checkOutput("restart_addr0", rdAddr[0], 32'h4000_0010);
        checkOutput("restart_pim0", pimWAddr[0], 32'd0);
        checkOutput("restart_err", errPulses, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
